// File: rtl/regfile_bypass.sv
// Multi-entry register file with one write port, two bypassed combinational
// read ports and a per-register pending scoreboard with a registered count.
module regfile_bypass #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  output logic             pend_any,
  output logic [AW:0]      pend_cnt
);

  logic [WIDTH-1:0] data_reg [NREGS];
  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;
  logic [AW:0]      cnt_reg;
  logic [AW:0]      cnt_next;
  logic             any_reg;

  logic wr_ok;
  logic rsv_ok;

  // rst_b is active-high here: while it is asserted nothing is written or reserved.
  assign wr_ok  = we     && !rst_b && !(ZERO_R0 && (waddr    == '0));
  assign rsv_ok = rsv_en && !rst_b && !(ZERO_R0 && (rsv_addr == '0));

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic wr_hit;
      logic rsv_hit;

      assign wr_hit  = wr_ok  && (waddr    == AW'(gi));
      assign rsv_hit = rsv_ok && (rsv_addr == AW'(gi));
      // A new reservation outranks a same-cycle write to the same register.
      assign pend_next[gi] = (pend_reg[gi] && !wr_hit) || rsv_hit;

      always_ff @(posedge clk) begin
        if (rst_b) begin
          data_reg[gi] <= '0;
        end else if (wr_hit) begin
          data_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign cnt_next = popcount(pend_next);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
      any_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
      any_reg  <= (cnt_next != '0);
    end
  end

  assign pend_cnt = cnt_reg;
  assign pend_any = any_reg;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic hit;
      logic zero;

      assign hit  = wr_ok && (rd_addr[gi] == waddr);
      assign zero = ZERO_R0 && (rd_addr[gi] == '0);

      // A same-cycle write both forwards its data and resolves busy.
      assign rd_data[gi] = zero ? '0 : (hit ? wdata : data_reg[rd_addr[gi]]);
      assign rd_busy[gi] = pend_reg[rd_addr[gi]] && !hit && !zero;
    end
  endgenerate

  assign ra_data = rd_data[0];
  assign ra_busy = rd_busy[0];
  assign rb_data = rd_data[1];
  assign rb_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: bypass, scoreboard, reset and R0 handling,
// with two instances (ZERO_R0 = 0 and 1) driven by the same stimulus.
module tb_regfile_bypass;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [AW-1:0]    ra_addr;
  logic [AW-1:0]    rb_addr;

  logic [WIDTH-1:0] ra_data, rb_data;
  logic             ra_busy, rb_busy, pend_any;
  logic [AW:0]      pend_cnt;

  logic [WIDTH-1:0] za_data, zb_data;
  logic             za_busy, zb_busy, zpend_any;
  logic [AW:0]      zpend_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bypass #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_R0(1'b0)) dut (
    .clk(clk), .rst_b(rst_b), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
    .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
    .pend_any(pend_any), .pend_cnt(pend_cnt)
  );

  regfile_bypass #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_b(rst_b), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_addr(ra_addr), .ra_data(za_data), .ra_busy(za_busy),
    .rb_addr(rb_addr), .rb_data(zb_data), .rb_busy(zb_busy),
    .pend_any(zpend_any), .pend_cnt(zpend_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; ra_addr = '0; rb_addr = '0;
    step();
    rst_b = 1'b0;
    ra_addr = 3'd3;
    #1;
    check("rst_cnt", pend_cnt, 0);
    check("rst_any", pend_any, 0);
    check("rst_r3", ra_data, 0);
    check("rst_busy", ra_busy, 0);

    // R3 write: bypass then storage
    we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
    #1 check("r3_bypass", ra_data, 16'h1234);
    step(); idle();
    #1 check("r3_stored", ra_data, 16'h1234);

    // Reserve R5, then resolve with a write
    rsv_en = 1'b1; rsv_addr = 3'd5; rb_addr = 3'd5;
    #1 check("r5_busy_same_cycle", rb_busy, 0);
    step(); idle();
    #1;
    check("r5_busy", rb_busy, 1);
    check("r5_cnt", pend_cnt, 1);
    check("r5_any", pend_any, 1);
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    #1;
    check("r5_wr_busy", rb_busy, 0);
    check("r5_wr_data", rb_data, 16'hBEEF);
    check("r5_wr_cnt", pend_cnt, 1);
    step(); idle();
    #1;
    check("r5_after_cnt", pend_cnt, 0);
    check("r5_after_any", pend_any, 0);
    check("r5_after_data", rb_data, 16'hBEEF);

    // Pend R2 and R4, then write+reserve R2 together
    rsv_en = 1'b1; rsv_addr = 3'd2; step();
    rsv_addr = 3'd4; step(); idle();
    #1 check("r2r4_cnt", pend_cnt, 2);
    we = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step(); idle();
    ra_addr = 3'd2;
    #1;
    check("r2_data", ra_data, 16'h00AA);
    check("r2_busy", ra_busy, 1);
    check("r2_cnt", pend_cnt, 2);

    // Reserve R1 while writing pending R4
    rsv_en = 1'b1; rsv_addr = 3'd1;
    we = 1'b1; waddr = 3'd4; wdata = 16'h4444;
    step(); idle();
    ra_addr = 3'd1; rb_addr = 3'd4;
    #1;
    check("r1_busy", ra_busy, 1);
    check("r4_busy", rb_busy, 0);
    check("r4_data", rb_data, 16'h4444);
    check("r1r4_cnt", pend_cnt, 2);

    // Third reservation plus R6 = 0x5555, then reset with a write in flight
    rsv_en = 1'b1; rsv_addr = 3'd7;
    we = 1'b1; waddr = 3'd6; wdata = 16'h5555;
    step(); idle();
    rb_addr = 3'd6;
    #1;
    check("pre_rst_cnt", pend_cnt, 3);
    check("pre_rst_r6", rb_data, 16'h5555);
    rst_b = 1'b1; we = 1'b1; waddr = 3'd6; wdata = 16'h1111;
    rsv_en = 1'b1; rsv_addr = 3'd3; ra_addr = 3'd6;
    #1 check("rst_no_bypass", ra_data, 16'h5555);
    step();
    rst_b = 1'b0; idle();
    #1;
    check("post_rst_cnt", pend_cnt, 0);
    check("post_rst_any", pend_any, 0);
    for (int i = 0; i < NREGS; i++) begin
      ra_addr = AW'(i); rb_addr = AW'(i);
      #1;
      check($sformatf("post_rst_data_r%0d", i), ra_data, 0);
      check($sformatf("post_rst_abusy_r%0d", i), ra_busy, 0);
      check($sformatf("post_rst_bbusy_r%0d", i), rb_busy, 0);
    end

    // R0 write+reserve on both instances
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 3'd0; ra_addr = 3'd0;
    #1;
    check("z_r0_bypass", za_data, 0);
    check("n_r0_bypass", ra_data, 16'hFFFF);
    step(); idle();
    #1;
    check("z_r0_data", za_data, 0);
    check("z_r0_busy", za_busy, 0);
    check("z_r0_cnt", zpend_cnt, 0);
    check("z_r0_any", zpend_any, 0);
    check("n_r0_data", ra_data, 16'hFFFF);
    check("n_r0_busy", ra_busy, 1);
    check("n_r0_cnt", pend_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
